// File: rtl/wb_openram_arbiter_if.sv
// Wishbone classic slave-side bundle (one master port of the OpenRAM arbiter).
// Field names keep the usual _i/_o direction suffixes as seen from the arbiter.
interface wb_openram_arbiter_if;
  logic        stb_i;
  logic        cyc_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic        ack_o;
  logic [31:0] dat_o;

  modport slave (
    input  stb_i, cyc_i, we_i, sel_i, adr_i, dat_i,
    output ack_o, dat_o
  );

  modport master (
    output stb_i, cyc_i, we_i, sel_i, adr_i, dat_i,
    input  ack_o, dat_o
  );
endinterface

// File: rtl/wb_openram_arbiter.sv
// Two-master round-robin Wishbone arbiter driving port 0 of one OpenRAM macro.
// Each grant runs IDLE -> MEM -> RESP -> ACK; the ack goes out three cycles after the request.
module wb_openram_arbiter #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  wb_openram_arbiter_if.slave   wbs_a,
  wb_openram_arbiter_if.slave   wbs_b,
  output logic                  clk0,
  output logic                  csb0,
  output logic                  web0,
  output logic [3:0]            wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [31:0]           dout0,
  input  logic [31:0]           din0
);

  localparam int unsigned WIN_BITS = ADDR_WIDTH + 2;
  localparam logic [31:0] WIN_MASK = ~((32'h1 << WIN_BITS) - 32'h1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  grant_q, grant_d;          // 1 = port B
  logic                  last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic                  ack_q, ack_d;
  logic                  csb0_q, csb0_d;
  logic                  web0_q, web0_d;
  logic [3:0]            wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [31:0]           dout0_q, dout0_d;
  logic [31:0]           dat_a_q, dat_a_d;
  logic [31:0]           dat_b_q, dat_b_d;

  logic hit_a, hit_b, grant_b;

  assign hit_a = wbs_a.stb_i & wbs_a.cyc_i & ((wbs_a.adr_i & WIN_MASK) == BASE_ADDR);
  assign hit_b = wbs_b.stb_i & wbs_b.cyc_i & ((wbs_b.adr_i & WIN_MASK) == BASE_ADDR);

  // On a tie the port that was not served last wins.
  assign grant_b = hit_b & (~hit_a | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    ack_d        = 1'b0;
    csb0_d       = csb0_q;
    web0_d       = web0_q;
    wmask0_d     = wmask0_q;
    addr0_d      = addr0_q;
    dout0_d      = dout0_q;
    dat_a_d      = dat_a_q;
    dat_b_d      = dat_b_q;

    case (state_q)
      S_IDLE: begin
        csb0_d = 1'b1;
        if (hit_a | hit_b) begin
          grant_d  = grant_b;
          we_d     = grant_b ? wbs_b.we_i : wbs_a.we_i;
          csb0_d   = 1'b0;
          web0_d   = grant_b ? ~wbs_b.we_i : ~wbs_a.we_i;
          wmask0_d = grant_b ? wbs_b.sel_i : wbs_a.sel_i;
          addr0_d  = grant_b ? wbs_b.adr_i[ADDR_WIDTH+1:2] : wbs_a.adr_i[ADDR_WIDTH+1:2];
          dout0_d  = grant_b ? wbs_b.dat_i : wbs_a.dat_i;
          state_d  = S_MEM;
        end
      end
      S_MEM: begin
        csb0_d   = 1'b1;
        web0_d   = 1'b1;
        wmask0_d = 4'h0;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (!we_q) begin
          if (grant_q) dat_b_d = din0;
          else         dat_a_d = din0;
        end
        ack_d   = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      ack_q        <= 1'b0;
      csb0_q       <= 1'b1;
      web0_q       <= 1'b1;
      wmask0_q     <= 4'h0;
      addr0_q      <= '0;
      dout0_q      <= 32'h0;
      dat_a_q      <= 32'h0;
      dat_b_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      ack_q        <= ack_d;
      csb0_q       <= csb0_d;
      web0_q       <= web0_d;
      wmask0_q     <= wmask0_d;
      addr0_q      <= addr0_d;
      dout0_q      <= dout0_d;
      dat_a_q      <= dat_a_d;
      dat_b_q      <= dat_b_d;
    end
  end

  // A master that dropped cyc mid-access sees no ack.
  assign wbs_a.ack_o = ack_q & ~grant_q & wbs_a.cyc_i;
  assign wbs_b.ack_o = ack_q &  grant_q & wbs_b.cyc_i;
  assign wbs_a.dat_o = dat_a_q;
  assign wbs_b.dat_o = dat_b_q;

  assign clk0   = wb_clk_i;
  assign csb0   = csb0_q;
  assign web0   = web0_q;
  assign wmask0 = wmask0_q;
  assign addr0  = addr0_q;
  assign dout0  = dout0_q;

endmodule

// File: doc/wb_openram_arbiter.md
# wb_openram_arbiter

Two-master Wishbone arbiter and sequencer for the RW port (port 0) of a single OpenRAM macro. Port A serves the management SoC bus and port B serves user-area logic. Requests that hit the RAM window are granted round-robin. Each granted request is launched on the macro as a registered single-cycle access, and the read data is returned with a one-cycle acknowledge. The block sits between the user-project Wishbone fabric and the SRAM macro, and it is the only driver of the macro's port-0 pins.

## Interface
- BASE_ADDR, 32'h3000_0000: byte base of the RAM window, aligned to 2^(ADDR_WIDTH+2).
- ADDR_WIDTH, 8: macro word-address width, giving 2^ADDR_WIDTH 32-bit words.
- wb_clk_i  in  1  single clock; also drives the macro clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- wbs_a_stb_i, wbs_a_cyc_i, wbs_a_we_i  in  1 each  port A Wishbone classic strobe, cycle and write enable.
- wbs_a_sel_i  in  4  port A byte selects.
- wbs_a_adr_i  in  32  port A byte address.
- wbs_a_dat_i  in  32  port A write data.
- wbs_a_ack_o  out  1  port A acknowledge.
- wbs_a_dat_o  out  32  port A read data.
- wbs_b_*  same set as port A, for port B.
- clk0  out  1  macro clock, equal to wb_clk_i.
- csb0  out  1  macro chip select, active low.
- web0  out  1  macro write enable, active low.
- wmask0  out  4  macro byte write mask.
- addr0  out  ADDR_WIDTH  macro word address.
- dout0  out  32  write data driven to the macro.
- din0  in  32  read data returned by the macro.

## Operation
- Hit condition for port X: stb & cyc & ((adr & ~(2^(ADDR_WIDTH+2)-1)) == BASE_ADDR).
  - A request that misses is ignored and is never acknowledged by this block.
- Word address: addr0 = adr[ADDR_WIDTH+1:2]. Bits adr[1:0] are ignored.
- FSM states: IDLE, MEM, RESP, ACK.
- IDLE:
  - If any port hits, select a grant. Register csb0=0, web0=~we, wmask0=sel, addr0 and dout0 from the granted port. Go to MEM.
  - Otherwise hold csb0=1 and stay in IDLE.
- MEM: csb0 is low for exactly this cycle, and the macro samples its inputs on the closing edge. Next-cycle register values: csb0=1, web0=1, wmask0=0. addr0 and dout0 hold. Go to RESP.
- RESP: din0 is valid. Capture din0 into the granted port's dat_o register, but only for reads; writes leave dat_o unchanged. Set the ack register. Go to ACK.
- ACK: the granted port's ack_o is 1 for this single cycle. Update last_grant to the granted port. Go to IDLE.
- Arbitration:
  - One hitting port: grant it.
  - Both hitting in IDLE: grant the port that is not last_grant.
  - Result: neither port waits more than one foreign access.
- The non-granted port's request is held pending, never acknowledged early, and is re-evaluated in the next IDLE.
- Abandon rule: ack_o = ack_reg & cyc_i of the granted port.
  - If the master drops cyc before ACK, the macro access still completes and no ack is shown.
  - The FSM still returns to IDLE normally.
- The grant is latched in IDLE. Request-input changes during MEM, RESP or ACK do not alter addr0, dout0 or the grant.

## Timing
- Uncontended access: request hits in IDLE in cycle 0. MEM is cycle 1, RESP is cycle 2, ack_o=1 in cycle 3, and the FSM is back in IDLE in cycle 4.
- Latency from request to ack is 3 cycles. Throughput is one access per 4 cycles.
- A master that holds stb after its ack is re-arbitrated in cycle 4 as a new request. Masters must drop stb in the ack cycle, per classic Wishbone.
- Reset values:
  - state=IDLE, csb0=1, web0=1, wmask0=0, addr0=0, dout0=0.
  - both ack_o=0 and both dat_o=0.
  - last_grant=B, so A wins the first tie.
- Reset asserted mid-access (MEM, RESP or ACK): on the next edge all of the above values are restored. No ack is issued, and the in-flight write may or may not have been committed.
- wb_rst_i high suppresses grants for as long as it is held.
- Address wrap: the word address is truncated to ADDR_WIDTH, and only in-window addresses reach the macro.
- Ack exclusivity: ack_a and ack_b are never 1 in the same cycle.

## Test plan
- Port A writes 32'hDEADBEEF with sel=4'hF at BASE_ADDR+8, then reads it back.
  - Required: csb0 low for exactly one cycle per access; addr0=2 and wmask0=F on the write; ack at request+3; read returns DEADBEEF on wbs_a_dat_o.
- Byte mask: write 32'h11223344 with sel=F, then write 32'hAABBCCDD with sel=4'b0101, then read.
  - Required: read returns 32'h11BB33DD, and wmask0=0101 during the second MEM cycle.
- Both ports hit in the same cycle straight after reset, and both keep requesting.
  - Required: A is acked at cycle 3 and B at cycle 7.
  - On the next simultaneous pair, B is served first (last_grant=A).
  - ack_a and ack_b are never high together.
- Miss: port B issues a request at BASE_ADDR + 2^(ADDR_WIDTH+2).
  - Required: csb0 stays 1, wbs_b_ack_o stays 0 for 10 cycles, and the FSM stays in IDLE.
- Abandon: port A drops cyc during RESP.
  - Required: wbs_a_ack_o stays 0, the FSM reaches IDLE at cycle 4, and a pending port-B request is then granted.
- Reset during RESP of a read.
  - Required: the next cycle shows all outputs at reset values with no ack.
  - A subsequent port-A read completes normally in 3 cycles.
